// File: rtl/switching_generator_mk2_pkg.sv
// Shared types for the switching keystream generator: FSM states, cfg_sel codes, width helper.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package swgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Configuration targets; codes 5..7 are reserved and ignored.
    typedef enum logic [2:0] {
        SEL_CTRL_SEED = 3'd0,
        SEL_CTRL_TAPS = 3'd1,
        SEL_DATA_SEED = 3'd2,
        SEL_MAT_A     = 3'd3,
        SEL_MAT_B     = 3'd4
    } cfg_sel_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/switching_generator_mk2_if.sv
// Bus bundle for switching_generator_mk2: config writes, run control, keystream handshake, status.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls the keystream; config has no backpressure.
// Ports: slave = generator side, master = driver/consumer side.
interface switching_generator_mk2_if #(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int CW = 32
) ();
    import swgen_pkg::*;

    localparam int DW = max_w(N, M);
    localparam int RW = $clog2(M);

    logic          cfg_we;
    logic [2:0]    cfg_sel;
    logic [RW-1:0] cfg_row;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic          stop;
    logic          out_bit;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          err;
    logic [CW-1:0] bit_count;

    modport slave (
        input  cfg_we, cfg_sel, cfg_row, cfg_data, start, stop, out_ready,
        output out_bit, out_valid, busy, err, bit_count
    );

    modport master (
        output cfg_we, cfg_sel, cfg_row, cfg_data, start, stop, out_ready,
        input  out_bit, out_valid, busy, err, bit_count
    );

endinterface

// File: rtl/switching_generator_mk2_gf2_matvec.sv
// Combinational M x M matrix times M-vector over GF(2); row i of res = parity(mat[i] & vec).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: mat (row i at mat[i]), vec, res.
module gf2_matvec #(
    parameter int M = 8
) (
    input  logic [M-1:0][M-1:0] mat,
    input  logic [M-1:0]        vec,
    output logic [M-1:0]        res
);

    always_comb begin
        res = '0;
        for (int i = 0; i < M; i++) begin
            res[i] = ^(mat[i] & vec);
        end
    end

endmodule

// File: rtl/switching_generator_mk2.sv
// Switching keystream generator: an N-bit control LFSR picks matrix A or B each step to advance x.
// Latency: start to first out_valid = 2 cycles; one keystream bit per cycle while accepted.
// Backpressure: out_valid && !out_ready freezes ctrl, x, out_bit and bit_count.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries cfg, start/stop,
//        out_bit/out_valid/out_ready handshake, busy/err status and bit_count.
module switching_generator_mk2
    import swgen_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int CW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    switching_generator_mk2_if.slave bus
);

    state_t               state;
    state_t               state_nxt;

    logic [N-1:0]         ctrl;
    logic [N-1:0]         taps;
    logic [N-1:0]         ctrl_nxt;
    logic [M-1:0]         x;
    logic [M-1:0]         x_nxt;
    logic [M-1:0][M-1:0]  mat_a;
    logic [M-1:0][M-1:0]  mat_b;
    logic [M-1:0][M-1:0]  mat_sel;

    logic                 out_bit_q;
    logic                 out_valid_q;
    logic [CW-1:0]        count_q;

    logic                 step;
    logic                 clr_count;
    logic                 cfg_en;
    logic                 row_ok;
    logic                 accept;

    // Matrix choice uses the control bit sampled before the shift.
    assign mat_sel  = ctrl[N-1] ? mat_b : mat_a;
    assign ctrl_nxt = {ctrl[N-2:0], ^(ctrl & taps)};

    gf2_matvec #(.M(M)) u_matvec (
        .mat (mat_sel),
        .vec (x),
        .res (x_nxt)
    );

    assign accept = out_valid_q && bus.out_ready;
    assign cfg_en = bus.cfg_we && (state == ST_IDLE);
    // Guards non-power-of-two M where cfg_row can exceed the matrix order.
    assign row_ok = (32'(bus.cfg_row) < 32'(M));

    // Next-state and per-cycle controls.
    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        clr_count = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    clr_count = 1'b1;
                    state_nxt = ((ctrl == '0) || (x == '0)) ? ST_ERR : ST_RUN;
                end
            end
            ST_RUN: begin
                // stop wins over both start and a pending step
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (!out_valid_q || bus.out_ready) begin
                    step = 1'b1;
                    if (x_nxt == '0) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Generator state and configuration registers; survive stop so a later start resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= N'(1);
            taps <= '0;
            x    <= M'(1);
            for (int i = 0; i < M; i++) begin
                mat_a[i] <= M'(1) << i;
                mat_b[i] <= M'(1) << i;
            end
        end else begin
            if (cfg_en) begin
                case (cfg_sel_t'(bus.cfg_sel))
                    SEL_CTRL_SEED: ctrl <= bus.cfg_data[N-1:0];
                    SEL_CTRL_TAPS: taps <= bus.cfg_data[N-1:0];
                    SEL_DATA_SEED: x    <= bus.cfg_data[M-1:0];
                    SEL_MAT_A: begin
                        if (row_ok) begin
                            mat_a[bus.cfg_row] <= bus.cfg_data[M-1:0];
                        end
                    end
                    SEL_MAT_B: begin
                        if (row_ok) begin
                            mat_b[bus.cfg_row] <= bus.cfg_data[M-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            // step only fires in RUN, so it never collides with a config write
            if (step) begin
                ctrl <= ctrl_nxt;
                x    <= x_nxt;
            end
        end
    end

    // Output stage: a zero state lands in ERR with out_valid already dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if ((state == ST_RUN) && bus.stop) begin
            out_valid_q <= 1'b0;
        end else if (step) begin
            out_bit_q   <= x_nxt[0];
            out_valid_q <= (x_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_count) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == ST_RUN);
    assign bus.err       = (state == ST_ERR);
    assign bus.bit_count = count_q;

endmodule

// File: doc/switching_generator_mk2.md
SWITCHING_GENERATOR_MK2 -- requirements
Module: switching_generator_mk2

Interface
REQ-001 SHALL have parameter N, default 8: control LFSR width (2..32).
REQ-002 SHALL have parameter M, default 8: data state width and matrix order (2..32).
REQ-003 SHALL have parameter CW, default 32: width of the delivered-bit counter.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_sel  input  3  target: 0 ctrl seed, 1 ctrl taps, 2 data seed, 3 matrix A row, 4 matrix B row; 5..7 reserved.
REQ-008 SHALL have port cfg_row  input  $clog2(M)  matrix row index for sel 3/4.
REQ-009 SHALL have port cfg_data  input  max(N,M)  write data, LSB-aligned.
REQ-010 SHALL have port start  input  1  run request pulse.
REQ-011 SHALL have port stop  input  1  halt/clear-error pulse.
REQ-012 SHALL have port out_bit  output  1  keystream bit.
REQ-013 SHALL have port out_valid  output  1  out_bit valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_bit.
REQ-015 SHALL have port busy  output  1  FSM in RUN.
REQ-016 SHALL have port err  output  1  FSM in ERR.
REQ-017 SHALL have port bit_count  output  CW  bits delivered since last start.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and ERR.
REQ-019 SHALL accept cfg_we only in IDLE; writes in RUN/ERR, reserved sel and out-of-range cfg_row ignored.
REQ-020 SHALL, in IDLE with start=1: go to ERR if ctrl state==0 or data state==0, else RUN; clear bit_count.
REQ-021 SHALL define a step as a pre-edge sample: c = ctrl[N-1]; ctrl <= {ctrl[N-2:0], ^(ctrl & taps)}; x <= c ? B·x : A·x over GF(2), row i of result = ^(row_i & x); out_bit <= new x[0].
REQ-022 SHALL perform a step in RUN when out_valid==0 or out_ready==1; otherwise hold all state (backpressure, out_bit stable).
REQ-023 SHALL assert out_valid after the first step; the first step occurs on the edge after the RUN entry edge, giving start-to-out_valid latency = 2 cycles.
REQ-024 SHALL increment bit_count on every cycle with out_valid && out_ready, wrapping modulo 2^CW.
REQ-025 SHALL, if a step yields x==0, go to ERR with out_valid=0 in the same edge.
REQ-026 SHALL, when stop=1 in RUN or ERR, go to IDLE and clear out_valid and err; stop takes priority over start and over a step in that cycle.
REQ-027 SHALL ignore start outside IDLE and stop in IDLE.
REQ-028 SHALL keep ctrl/x state across stop, so a later start resumes the sequence unless seeds are rewritten.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force IDLE, out_valid=0, out_bit=0, err=0, busy=0, bit_count=0, ctrl=1, taps=0, x=1, and A=B=identity.
REQ-030 SHALL release reset synchronously to clk; a reset asserted mid-RUN drops out_valid immediately.

Structure
REQ-031 SHALL place the FSM state enum, cfg_sel encodings and a max-width helper in shared package swgen_pkg.
REQ-032 SHALL use one sub-module gf2_matvec (parameter M; combinational M×M matrix times M-vector over GF(2)), instantiated once with a muxed matrix.

Verification
REQ-033 SHALL cover: N=M=4, A=B=identity, x=4'b0101, ctrl=1, taps=4'b1001, start, out_ready=1 -> out_valid at cycle 2, out_bit constant 1, bit_count=10 after 10 accepts.
REQ-034 SHALL cover: A=B=rotate-left, x=4'b0001 -> out_bit stream 0,0,0,1 repeating.
REQ-035 SHALL cover: out_ready=0 for 5 cycles mid-run -> out_bit, bit_count and state frozen; resumes with the same next bit.
REQ-036 SHALL cover: data seed 0 then start -> err=1, busy=0 next cycle; stop -> IDLE, err=0.
REQ-037 SHALL cover: cfg_we during RUN changing A -> sequence unchanged; stop+start in the same cycle -> IDLE.
REQ-038 SHALL cover: rst_n pulsed low mid-run between clock edges -> outputs at reset values before the next edge.
